up_core_loader: RTL and testbench

Host-side controller that sequences the `up_core` memory-map port. It accepts a byte-stream command protocol from a host link (valid/ready), and turns it into `mem_map_load`, `mem_map_address` and `mem_map_in` cycles. It performs single writes, single reads, burst writes and core start. It sits between the host byte link and `up_core` and is the only driver of the core's memory-map inputs.

---
 rtl/up_core_loader.sv | 155 +++++++++++++++
 tb/tb_up_core_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_core_loader.sv
// up_core_loader: decodes the host byte-stream command protocol into up_core memory-map cycles.
// Latency: write/start strobe one cycle after the last byte; response one cycle after the strobe.
// Backpressure: host_ready low while a command executes or a response waits for resp_ready.
module up_core_loader #(
    parameter logic [7:0] ACK = 8'hAA,
    parameter logic [7:0] NAK = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_valid,
    input  logic [7:0] host_data,
    output logic       host_ready,
    output logic       resp_valid,
    output logic [7:0] resp_data,
    input  logic       resp_ready,
    output logic       mem_map_load,
    output logic [8:0] mem_map_address,
    output logic [7:0] mem_map_in,
    input  logic [7:0] mem_map_out,
    output logic       busy,
    output logic       err
);

    typedef enum logic [3:0] {
        S_IDLE, S_GET_ADDR, S_GET_CNT, S_WRITE_DATA, S_GET_DATA,
        S_WRITE, S_READ, S_START, S_RESP
    } state_t;

    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_BURST} op_t;

    state_t     state;
    op_t        op;
    logic [7:0] addr;
    logic [8:0] cnt;
    logic       xfer;

    assign xfer = host_valid & host_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            op              <= OP_WRITE;
            addr            <= 8'h00;
            cnt             <= 9'h000;
            host_ready      <= 1'b0;
            resp_valid      <= 1'b0;
            resp_data       <= 8'h00;
            mem_map_load    <= 1'b0;
            mem_map_address <= 9'h000;
            mem_map_in      <= 8'h00;
            busy            <= 1'b0;
            err             <= 1'b0;
        end else begin
            mem_map_load <= 1'b0;
            err          <= 1'b0;
            case (state)
                S_IDLE: begin
                    host_ready <= 1'b1;
                    if (xfer) begin
                        busy <= 1'b1;
                        case (host_data)
                            8'h01, 8'h02, 8'h03: begin
                                op    <= (host_data == 8'h01) ? OP_WRITE :
                                         (host_data == 8'h02) ? OP_READ : OP_BURST;
                                state <= S_GET_ADDR;
                            end
                            8'h04: begin
                                host_ready      <= 1'b0;
                                mem_map_load    <= 1'b1;
                                mem_map_address <= 9'h100;
                                state           <= S_START;
                            end
                            default: begin
                                host_ready <= 1'b0;
                                resp_valid <= 1'b1;
                                resp_data  <= NAK;
                                err        <= 1'b1;
                                state      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_GET_ADDR: begin
                    if (xfer) begin
                        addr <= host_data;
                        case (op)
                            OP_WRITE: state <= S_WRITE_DATA;
                            OP_READ: begin
                                // Address goes out now so the core's combinational read settles in READ.
                                host_ready      <= 1'b0;
                                mem_map_address <= {1'b0, host_data};
                                state           <= S_READ;
                            end
                            default:  state <= S_GET_CNT;
                        endcase
                    end
                end
                S_GET_CNT: begin
                    if (xfer) begin
                        cnt   <= (host_data == 8'h00) ? 9'd256 : {1'b0, host_data};
                        state <= S_GET_DATA;
                    end
                end
                S_WRITE_DATA, S_GET_DATA: begin
                    if (xfer) begin
                        host_ready      <= 1'b0;
                        mem_map_load    <= 1'b1;
                        mem_map_address <= {1'b0, addr};
                        mem_map_in      <= host_data;
                        state           <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (op == OP_BURST && cnt != 9'd1) begin
                        addr       <= addr + 8'd1;
                        cnt        <= cnt - 9'd1;
                        host_ready <= 1'b1;
                        state      <= S_GET_DATA;
                    end else begin
                        addr       <= addr + 8'd1;
                        cnt        <= 9'd0;
                        resp_valid <= 1'b1;
                        resp_data  <= ACK;
                        state      <= S_RESP;
                    end
                end
                S_READ: begin
                    resp_valid <= 1'b1;
                    resp_data  <= mem_map_out;
                    state      <= S_RESP;
                end
                S_START: begin
                    resp_valid <= 1'b1;
                    resp_data  <= ACK;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        host_ready <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    host_ready <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_core_loader.sv
// tb_up_core_loader: directed and randomized command traffic against a byte-level memory model.
// Latency and handshake timing checked at fixed cycle offsets; responses and strobes scoreboarded.
module tb_up_core_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_valid = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_ready = 1'b0;
    logic       mem_map_load;
    logic [8:0] mem_map_address;
    logic [7:0] mem_map_in;
    logic [7:0] mem_map_out;
    logic       busy;
    logic       err;

    localparam logic [7:0] ACK = 8'hAA;
    localparam logic [7:0] NAK = 8'hEE;

    always #5 clk = ~clk;

    up_core_loader #(.ACK(ACK), .NAK(NAK)) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .mem_map_load(mem_map_load), .mem_map_address(mem_map_address),
        .mem_map_in(mem_map_in), .mem_map_out(mem_map_out),
        .busy(busy), .err(err)
    );

    // Stand-in for the core's memory: combinational read, written by load strobes.
    logic [7:0] core_mem [256];
    logic       init_mem = 1'b1;
    assign mem_map_out = core_mem[mem_map_address[7:0]];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) core_mem[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_map_load && !mem_map_address[8]) begin
            core_mem[mem_map_address[7:0]] <= mem_map_in;
        end
    end

    logic [16:0] pulses [$];
    logic [16:0] exp_pulses [$];
    int          err_cycles = 0;
    always @(posedge clk) begin
        if (mem_map_load) pulses.push_back({mem_map_address, mem_map_in});
        if (err) err_cycles <= err_cycles + 1;
    end

    logic [7:0] ref_mem [256];
    int vectors = 0;
    int miscompares = 0;
    int nak_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        host_valid = 1'b1;
        host_data  = b;
        t = 0;
        do begin @(negedge clk); t++; end while (!host_ready && t < 400);
        if (!host_ready) chk("host_ready_wait", host_ready, 1);
        @(posedge clk); #1;
        host_valid = 1'b0;
    endtask

    task automatic recv(input logic [7:0] exp, input string tag, input int delay);
        int t;
        repeat (delay) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!resp_valid && t < 400);
        chk({tag, "_vld"}, resp_valid, 1);
        chk(tag, resp_data, exp);
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d, input int maxgap);
        send(8'h01, $urandom_range(0, maxgap));
        send(a, $urandom_range(0, maxgap));
        send(d, $urandom_range(0, maxgap));
        exp_pulses.push_back({1'b0, a, d});
        ref_mem[a] = d;
        recv(ACK, "write_ack", $urandom_range(0, 3));
    endtask

    task automatic cmd_read(input logic [7:0] a, input int maxgap);
        send(8'h02, $urandom_range(0, maxgap));
        send(a, $urandom_range(0, maxgap));
        recv(ref_mem[a], "read_data", $urandom_range(0, 3));
    endtask

    task automatic cmd_burst(input logic [7:0] a, input logic [7:0] c, input bit fixed, input int maxgap);
        int n;
        logic [7:0] d, ad;
        n = (c == 8'h00) ? 256 : int'(c);
        send(8'h03, $urandom_range(0, maxgap));
        send(a, $urandom_range(0, maxgap));
        send(c, $urandom_range(0, maxgap));
        for (int i = 0; i < n; i++) begin
            d  = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            ad = 8'(int'(a) + i);
            exp_pulses.push_back({1'b0, ad, d});
            ref_mem[ad] = d;
            send(d, $urandom_range(0, maxgap));
        end
        recv(ACK, "burst_ack", $urandom_range(0, 3));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_host_ready"}, host_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_load"}, mem_map_load, 0);
        chk({tag, "_addr"}, mem_map_address, 0);
        chk({tag, "_in"}, mem_map_in, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready_low", host_ready, 0);
        @(negedge clk);
        chk("rel_ready_high", host_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int p0, kind;
        logic [7:0] a, d, op;
        logic [255:0] seen;
        logic [16:0] p, e;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

        // Power-on reset
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        init_mem = 1'b0;
        release_reset();

        // WRITE 01 3C A5 with exact strobe/response timing
        send(8'h01, 0); send(8'h3C, 0); send(8'hA5, 0);
        exp_pulses.push_back({9'h03C, 8'hA5});
        ref_mem[8'h3C] = 8'hA5;
        @(negedge clk);
        chk("wr_load", mem_map_load, 1);
        chk("wr_addr", mem_map_address, 9'h03C);
        chk("wr_in", mem_map_in, 8'hA5);
        chk("wr_resp_early", resp_valid, 0);
        @(negedge clk);
        chk("wr_load_once", mem_map_load, 0);
        chk("wr_resp_vld", resp_valid, 1);
        chk("wr_resp_ack", resp_data, ACK);
        @(posedge clk); #1;
        recv(ACK, "wr_ack", 0);
        @(negedge clk);
        chk("wr_idle_ready", host_ready, 1);
        chk("wr_idle_busy", busy, 0);
        chk("wr_addr_held", mem_map_address, 9'h03C);
        @(posedge clk); #1;

        // READ 02 3C
        send(8'h02, 0); send(8'h3C, 0);
        @(negedge clk);
        chk("rd_addr", mem_map_address, 9'h03C);
        chk("rd_resp_early", resp_valid, 0);
        chk("rd_busy", busy, 1);
        @(negedge clk);
        chk("rd_resp_vld", resp_valid, 1);
        chk("rd_resp_data", resp_data, 8'hA5);
        @(posedge clk); #1;
        recv(8'hA5, "rd_data", 0);

        // BURST FE x3 wrapping through 00, gapped host bytes
        p0 = pulses.size();
        cmd_burst(8'hFE, 8'h03, 1'b1, 3);
        chk("burst3_pulses", pulses.size() - p0, 3);
        @(negedge clk);
        chk("burst3_single_ack", resp_valid, 0);
        @(posedge clk); #1;

        // START
        send(8'h04, 0);
        exp_pulses.push_back({9'h100, 8'h00});
        @(negedge clk);
        chk("start_load", mem_map_load, 1);
        chk("start_addr", mem_map_address, 9'h100);
        @(negedge clk);
        chk("start_load_once", mem_map_load, 0);
        chk("start_resp", resp_data, ACK);
        @(posedge clk); #1;
        recv(ACK, "start_ack", 1);

        // Unknown opcode
        send(8'h7F, 0);
        nak_count++;
        @(negedge clk);
        chk("nak_vld", resp_valid, 1);
        chk("nak_data", resp_data, NAK);
        chk("nak_err", err, 1);
        @(negedge clk);
        chk("nak_err_pulse", err, 0);
        chk("nak_held", resp_valid, 1);
        @(posedge clk); #1;
        recv(NAK, "nak", 2);

        // Randomized command mix against the reference memory
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 4);
            a = 8'($urandom);
            d = 8'($urandom);
            case (kind)
                0: cmd_write(a, d, 2);
                1: cmd_read(a, 2);
                2: cmd_burst(a, 8'($urandom_range(1, 6)), 1'b0, 2);
                3: begin
                    op = 8'($urandom_range(5, 255));
                    send(op, $urandom_range(0, 2));
                    nak_count++;
                    recv(NAK, "rand_nak", $urandom_range(0, 3));
                end
                default: begin
                    send(8'h04, $urandom_range(0, 2));
                    exp_pulses.push_back({9'h100, 8'h00});
                    recv(ACK, "rand_start", $urandom_range(0, 3));
                end
            endcase
        end

        // BURST of 256 covering every address once
        p0 = pulses.size();
        cmd_burst(8'h80, 8'h00, 1'b0, 0);
        chk("burst256_pulses", pulses.size() - p0, 256);
        seen = '0;
        for (int i = p0; i < pulses.size(); i++) begin
            p = pulses[i];
            seen[p[15:8]] = 1'b1;
        end
        chk("burst256_cover", $countones(seen), 256);

        // Response backpressure, then reset drops the pending response
        d = 8'($urandom);
        send(8'h01, 0); send(8'h40, 0); send(d, 0);
        exp_pulses.push_back({9'h040, d});
        ref_mem[8'h40] = d;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_vld", resp_valid, 1);
            chk("bp_data", resp_data, ACK);
            chk("bp_ready", host_ready, 0);
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_resp");
        release_reset();

        // Reset between BURST data bytes
        send(8'h03, 0); send(8'h10, 0); send(8'h05, 0);
        d = 8'($urandom); send(d, 0);
        exp_pulses.push_back({9'h010, d}); ref_mem[8'h10] = d;
        d = 8'($urandom); send(d, 1);
        exp_pulses.push_back({9'h011, d}); ref_mem[8'h11] = d;
        @(posedge clk); #3;
        rst = 1'b1;
        p0 = pulses.size();
        #1 check_reset_outputs("rst_burst");
        release_reset();
        repeat (10) @(posedge clk);
        #1;
        chk("rst_burst_no_pulse", pulses.size() - p0, 0);
        chk("rst_burst_idle", busy, 0);
        cmd_read(8'h11, 0);
        cmd_read(8'h12, 0);

        // Scoreboard of every load strobe
        chk("pulse_count", pulses.size(), exp_pulses.size());
        for (int i = 0; i < pulses.size() && i < exp_pulses.size(); i++) begin
            p = pulses[i];
            e = exp_pulses[i];
            chk("pulse_addr", p[16:8], e[16:8]);
            if (!e[16]) chk("pulse_data", p[7:0], e[7:0]);
        end
        chk("err_pulses", err_cycles, nak_count);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
